spi_xfer_sched: RTL and testbench
=================================

Name: spi_xfer_sched

Overview:
- Round-robin scheduler that shares one SPI byte engine (clock divider plus shifter) between NUM_REQ requesters.
- Grants one requester per transaction and owns its chip select, CS setup/hold timing and inter-transaction gap.
- Issues one tx_valid pulse per byte and paces bytes on the engine's tx_rdy.
- Sits between the host-side request ports and the SPI engine's i_tx_valid/i_cpol/o_tx_rdy pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LEN_W, 4, burst length field width; a transaction carries len+1 bytes.
- CS_SETUP, 2, cycles CS is low before the first tx_valid (>=1).
- CS_HOLD, 2, cycles CS stays low after the last tx_rdy (>=1).
- GAP, 3, cycles all CS are high before the next grant (>=1).
- TIMEOUT, 255, max WAIT cycles for tx_rdy before abort.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous and active-high.
- i_req  in  NUM_REQ  per-requester request; held until own o_done.
- i_req_cpol  in  NUM_REQ  per-requester CPOL.
- i_req_len  in  NUM_REQ*LEN_W  bytes-minus-one, packed, requester 0 in LSBs.
- i_req_data  in  NUM_REQ*8  current byte per requester, packed.
- o_data_pop  out  NUM_REQ  1-cycle pulse; granted requester advances to its next byte.
- o_grant  out  NUM_REQ  one-hot current owner.
- o_done  out  NUM_REQ  1-cycle completion pulse.
- o_err  out  1  1-cycle timeout pulse.
- o_busy  out  1  high whenever state != IDLE.
- o_cs_n  out  NUM_REQ  active-low chip selects.
- o_tx_valid  out  1  start-byte pulse to the engine.
- o_tx_data  out  8  byte for the engine.
- o_cpol  out  1  CPOL to the engine.
- i_tx_rdy  in  1  engine byte-complete pulse.

Behaviour:
- Reset (synchronous, i_rst=1 at posedge):
  - o_cs_n all 1; o_grant, o_data_pop, o_done, o_err, o_tx_valid, o_tx_data, o_cpol and o_busy all 0.
  - State IDLE; RR pointer 0. Reset mid-transaction aborts immediately with no o_done.
- All outputs are registered.
- States: IDLE, SETUP, LOAD, WAIT, HOLD, GAP.
- IDLE:
  - When any i_req is high, pick the first requester at or after the pointer (wrapping).
  - Next cycle: o_grant[g]=1, o_cs_n[g]=0; latch cpol, len and g; pointer = (g+1) mod NUM_REQ; go to SETUP.
- SETUP: stays CS_SETUP cycles, then LOAD.
- LOAD: exactly one cycle.
  - o_tx_valid=1, o_tx_data=i_req_data[g], o_data_pop[g]=1, o_cpol=latched cpol.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - On i_tx_rdy=1 with bytes_left=0, go to HOLD. With bytes_left>0, decrement bytes_left and go to LOAD, so the next tx_valid appears 1 cycle after rdy.
  - The timeout counter increments every cycle. If it reaches TIMEOUT without rdy: pulse o_err for 1 cycle and go to HOLD; the remaining bytes are dropped.
  - If rdy and timeout occur in the same cycle, rdy wins.
- i_tx_rdy is ignored in every state except WAIT.
- HOLD: CS stays low for CS_HOLD cycles, then GAP.
- GAP:
  - On entry: o_cs_n all 1, o_grant=0, o_done[g] pulses on the first GAP cycle.
  - Stays GAP cycles, then IDLE.
- o_cpol holds its value after a transaction and changes only at grant, so it is stable from the SETUP start through the end of HOLD.
- Deasserting i_req mid-transaction is ignored; the transaction runs to completion.
- bytes_left is LEN_W bits. len=all-ones gives 2^LEN_W bytes with no wrap.
- Only one CS is low at any time; at most one tx_valid per byte.

Decomposition:
- Shared package spi_ctrl_pkg holds:
  - the state encoding constants (IDLE..GAP);
  - the default CS_SETUP, CS_HOLD, GAP and TIMEOUT values;
  - the byte-width constant 8.
- One sub-module, spi_rr_arbiter: takes the request vector and pointer, returns a one-hot grant plus index. Combinational pick; the pointer register lives in the parent.
- The parent holds the FSM, counters and output registers.

Test Plan:
- Single transfer: req0, len=0, data=0xA5, cpol=0; rdy 64 cycles after tx_valid.
  - cs_n[0] low 2 cycles before one tx_valid with data 0xA5, cpol 0.
  - cs_n[0] rises 2 cycles after rdy; done[0] pulses on that same cycle; busy falls 3 cycles later.
- Burst: req1, len=3, data 0x11/0x22/0x33/0x44 advanced on pop, cpol=1.
  - 4 tx_valid pulses with those bytes in order, each exactly 1 cycle after rdy.
  - 4 pops; cs_n[1] low continuously; o_cpol=1 throughout.
- Arbitration: req0 and req1 held high from reset.
  - Grants go 0,1,0,1; never two CS low at once.
  - Each gap between CS rise and the next CS fall is >= 3 cycles.
- Timeout: req0, len=2, no rdy ever.
  - After 255 WAIT cycles: o_err pulses once, no further tx_valid.
  - cs_n[0] rises 2 cycles later and done[0] pulses.
- Spurious rdy: pulse i_tx_rdy in IDLE, SETUP and the LOAD cycle. No state change and no byte skipped; the transfer completes normally on the real rdy.
- Reset mid-WAIT of burst len=3: i_rst high 1 cycle.
  - Next cycle all cs_n=1, grant=0, no done.
  - Pointer is 0, so simultaneous req0/req1 are granted req0 first.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared state encoding and timing defaults for the SPI transfer scheduler
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam int BYTE_W       = 8;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_GAP      = 3;
    localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin pick starting at the supplied pointer
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    int k;

    // Scan from the farthest offset down so the requester nearest the pointer wins last.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        k       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[k]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(k);
                grant_o    = '0;
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// rtl/spi_xfer_sched.sv - round-robin transaction scheduler sharing one SPI byte engine
module spi_xfer_sched
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int GAP      = DEF_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ-1:0]       i_req_cpol,
    input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
    input  logic [NUM_REQ*8-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]       o_data_pop,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_err,
    output logic                     o_busy,
    output logic [NUM_REQ-1:0]       o_cs_n,
    output logic                     o_tx_valid,
    output logic [7:0]               o_tx_data,
    output logic                     o_cpol,
    input  logic                     i_tx_rdy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    state_e               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     g_q;
    logic [LEN_W-1:0]     bytes_left_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [TO_W-1:0]      tout_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   cs_n_q;
    logic [NUM_REQ-1:0]   pop_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 tx_valid_q;
    logic [BYTE_W-1:0]    tx_data_q;
    logic                 cpol_q;

    logic                 arb_any;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .any_o   (arb_any),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            g_q          <= '0;
            bytes_left_q <= '0;
            cnt_q        <= '0;
            tout_q       <= '0;
            grant_q      <= '0;
            cs_n_q       <= '1;
            pop_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            cpol_q       <= 1'b0;
        end else begin
            pop_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q      <= arb_grant;
                        cs_n_q       <= ~arb_grant;
                        g_q          <= arb_idx;
                        cpol_q       <= i_req_cpol[arb_idx];
                        bytes_left_q <= i_req_len[int'(arb_idx)*LEN_W +: LEN_W];
                        ptr_q        <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETUP;
                    end
                end
                // Byte strobes are registered on entry so they coincide with the LOAD cycle.
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= i_req_data[int'(g_q)*BYTE_W +: BYTE_W];
                        pop_q      <= grant_q;
                        state_q    <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    tout_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_rdy) begin
                        if (bytes_left_q == '0) begin
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            bytes_left_q <= bytes_left_q - 1'b1;
                            tx_valid_q   <= 1'b1;
                            tx_data_q    <= i_req_data[int'(g_q)*BYTE_W +: BYTE_W];
                            pop_q        <= grant_q;
                            state_q      <= ST_LOAD;
                        end
                    end else if (tout_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        tout_q <= tout_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cs_n_q  <= '1;
                        grant_q <= '0;
                        done_q  <= grant_q;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_data_pop = pop_q;
    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_cs_n     = cs_n_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_cpol     = cpol_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb/tb_spi_xfer_sched.sv - self-checking bench for spi_xfer_sched
module tb_spi_xfer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  cpol = '0;
    logic [7:0]  len = '0;
    logic [15:0] data = '0;
    logic        rdy = 1'b0;
    logic [1:0]  pop, grant, done, cs_n;
    logic        err, busy, tv, ocpol;
    logic [7:0]  tdata;

    int checks = 0;
    int failures = 0;

    spi_xfer_sched dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_cpol (cpol),
        .i_req_len  (len),
        .i_req_data (data),
        .o_data_pop (pop),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_cs_n     (cs_n),
        .o_tx_valid (tv),
        .o_tx_data  (tdata),
        .o_cpol     (ocpol),
        .i_tx_rdy   (rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        int         len;
        bit         cpol;
        logic [7:0] d0;
        int         dly;
        bit         spur;
        int         exp_tv;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("one_cs_low", 32'($countones(~cs_n) <= 1), 1);
    endtask

    // Drives one single-requester transaction and models requester data plus engine rdy.
    task automatic run_vec(input vec_t v);
        int c = 0, t_cs = -1, t_rise = -1, t_done = -1, t_err = -1;
        int t_tv = -1, t_rdy = -1, rdy_at = -1;
        int n_tv = 0, n_pop = 0, n_err = 0, n_fall = 0;
        bit cs_prev = 1'b1, finished = 1'b0;
        logic [7:0] exp_b;
        len[v.r*4 +: 4]  = 4'(v.len);
        cpol[v.r]        = v.cpol;
        data[v.r*8 +: 8] = v.d0;
        req[v.r]         = 1'b1;
        rdy              = v.spur;
        while (c < 2000) begin
            step();
            c++;
            rdy = 1'b0;
            if (!cs_n[v.r] && cs_prev) begin
                n_fall++;
                t_cs = c;
                chk("grant", 32'(grant), 32'(1 << v.r));
                chk("cpol_at_grant", 32'(ocpol), 32'(v.cpol));
                if (v.spur) rdy = 1'b1;
            end
            if (cs_n[v.r] && !cs_prev) t_rise = c;
            cs_prev = cs_n[v.r];
            if (tv) begin
                exp_b = v.d0 + 8'(n_tv * 17);
                chk("tx_data", 32'(tdata), 32'(exp_b));
                chk("tx_cpol", 32'(ocpol), 32'(v.cpol));
                if (n_tv == 0) chk("setup_cycles", c - t_cs, 2);
                else           chk("rdy_to_valid", c - t_rdy, 1);
                n_tv++;
                t_tv = c;
                if (v.dly > 0) rdy_at = c + v.dly;
                if (v.spur && n_tv == 1) rdy = 1'b1;
            end
            if (c == rdy_at) begin
                rdy   = 1'b1;
                t_rdy = c;
            end
            if (pop[v.r]) begin
                n_pop++;
                data[v.r*8 +: 8] = v.d0 + 8'(n_pop * 17);
            end
            if (err) begin
                n_err++;
                t_err = c;
                chk("err_latency", c - t_tv, 256);
            end
            if (done[v.r]) begin
                t_done   = c;
                req[v.r] = 1'b0;
                chk("done_cs_high", 32'(cs_n[v.r]), 1);
                chk("done_at_rise", c, t_rise);
            end
            if (t_done > 0 && !busy) begin
                chk("busy_fall", c - t_done, 3);
                finished = 1'b1;
                break;
            end
        end
        rdy = 1'b0;
        chk("xfer_finished", 32'(finished), 1);
        chk("n_tx_valid", n_tv, v.exp_tv);
        chk("n_pop", n_pop, v.exp_tv);
        chk("n_err", n_err, 32'(v.exp_err));
        chk("cs_falls", n_fall, 1);
        if (v.exp_err) chk("hold_after_err", t_rise - t_err, 2);
        else           chk("hold_after_rdy", t_rise - t_rdy, 3);
    endtask

    initial begin
        vecs[0] = '{0, 0,  1'b0, 8'hA5, 64, 1'b0, 1,  1'b0};
        vecs[1] = '{1, 3,  1'b1, 8'h11, 5,  1'b0, 4,  1'b0};
        vecs[2] = '{0, 2,  1'b0, 8'h3C, 0,  1'b0, 1,  1'b1};
        vecs[3] = '{0, 1,  1'b1, 8'h70, 3,  1'b1, 2,  1'b0};
        vecs[4] = '{1, 15, 1'b0, 8'hF0, 1,  1'b0, 16, 1'b0};

        step();
        step();
        chk("rst_cs_n", 32'(cs_n), 3);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_pop", 32'(pop), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_tv", 32'(tv), 0);
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_cpol", 32'(ocpol), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Arbitration: both requesters held high from reset.
        begin
            int order[4];
            int n = 0, c = 0, prev_rise = -1, rdy_at = -1;
            logic [1:0] csp = 2'b11;
            req  = 2'b11;
            len  = 8'h00;
            data = 16'hBBAA;
            while (c < 400) begin
                step();
                c++;
                rdy = 1'b0;
                if (tv) rdy_at = c + 2;
                if (c == rdy_at) rdy = 1'b1;
                if ((csp & ~cs_n) != 2'b00) begin
                    if (n < 4) order[n] = cs_n[0] ? 1 : 0;
                    if (prev_rise >= 0) chk("gap_ge3", 32'((c - prev_rise) >= 3), 1);
                    n++;
                    if (n == 4) req = 2'b00;
                end
                if ((~csp & cs_n) != 2'b00) prev_rise = c;
                csp = cs_n;
                if (n >= 4 && !busy) break;
            end
            rdy = 1'b0;
            chk("arb_grants", n, 4);
            chk("arb_g0", order[0], 0);
            chk("arb_g1", order[1], 1);
            chk("arb_g2", order[2], 0);
            chk("arb_g3", order[3], 1);
        end

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // Reset in WAIT of a req0 burst: pointer must return to 0.
        begin
            int c = 0;
            len  = 8'h03;
            data = 16'h665A;
            req  = 2'b01;
            while (c < 50 && !tv) begin
                step();
                c++;
            end
            chk("rst_seq_tv_seen", 32'(tv), 1);
            step();
            step();
            step();
            req = 2'b11;
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("mid_rst_cs_n", 32'(cs_n), 3);
            chk("mid_rst_grant", 32'(grant), 0);
            chk("mid_rst_done", 32'(done), 0);
            chk("mid_rst_busy", 32'(busy), 0);
            step();
            chk("post_rst_grant", 32'(grant), 1);
            chk("post_rst_done", 32'(done), 0);
            req = 2'b00;
            rst = 1'b1;
            step();
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
